// File: rtl/prueba_pkg.sv
// Shared definitions for the PS/2 host controller: FSM states, frame
// geometry, the stream-mode command/response bytes and a parity helper.
`timescale 1ns/1ps
package prueba_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX_INHIBIT,
        ST_TX_REQ,
        ST_TX_BITS,
        ST_TX_ACK
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;   // "enable data reporting"
    localparam logic [7:0] RESP_ACK   = 8'hFA;   // device acknowledge

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/prueba_ps2_line_filter.sv
// Synchroniser, glitch filter and falling-edge detector for one PS/2 line.
// The filtered level only changes after DEPTH equal consecutive samples;
// a filtered 1->0 transition produces a one-cycle strobe.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic fall
);

    logic [1:0]       sync;
    logic [DEPTH-1:0] hist;
    logic             level;

    // Two-flop synchroniser, sample history, filtered level and edge strobe.
    // Everything resets to the released (high) line level so that leaving
    // reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register here reading
            // the previous-cycle values, which is what makes the shift chain work.
            sync  <= {sync[0], line};
            hist  <= {hist[DEPTH-2:0], sync[1]};
            fall  <= level & ~(|hist);
            if (&hist)
                level <= 1'b1;
            else if (~(|hist))
                level <= 1'b0;
        end
    end

endmodule

// File: rtl/prueba.sv
// PS/2 host controller: receives device frames, transmits host commands
// with the inhibit/request-to-send handshake, tracks the device response
// to the last command and whether the device has entered stream mode.
`timescale 1ns/1ps
module prueba
    import prueba_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire        PS2CLK,
    inout  wire        PS2DATA,
    input  logic [7:0] datain,
    input  logic       tx_write,
    output logic       tx_done,
    output logic [7:0] dataout,
    output logic       rx_done,
    output logic [7:0] DatoRec,
    output logic       STREAM,
    output logic       FAIL
);

    localparam int unsigned CYC_PER_US     = CLK_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYCLES = CYC_PER_US * INHIBIT_US;
    localparam int unsigned TIMEOUT_CYCLES = CYC_PER_US * TIMEOUT_US;
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // RX counts the strobes after the start bit; the last one is the stop bit.
    localparam logic [3:0] RX_LAST = 4'(FRAME_BITS - 2);
    // TX_BITS is entered presenting d0; its last strobe releases for the stop bit.
    localparam logic [3:0] TX_LAST = 4'(FRAME_BITS - 3);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       rx_shift;     // {parity, d7..d0} once all bits are in
    logic [8:0]       tx_shift;     // bit 0 is the bit currently on the line
    logic [1:0]       data_sync;
    logic             data_s;
    logic             strobe;
    logic [7:0]       last_sent;
    logic             await_resp;

    logic clk_low, data_low;
    logic cnt_restart, timeout, frame_ok;
    logic load_tx, shift_tx, shift_rx, finish_rx, ack_ok, raise_fail;

    ps2_line_filter #(.DEPTH(8)) u_clk_filter (
        .clk   (CLK),
        .rst_n (RST),
        .line  (PS2CLK),
        .fall  (strobe)
    );

    // Open-drain drivers: only ever pull low or let go.
    assign PS2CLK  = clk_low  ? 1'b0 : 1'bz;
    assign PS2DATA = data_low ? 1'b0 : 1'bz;

    assign data_s   = data_sync[1];
    assign timeout  = (cnt == TIMEOUT_LAST);
    assign frame_ok = data_s & (^rx_shift);

    // Data line synchroniser.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) data_sync <= 2'b11;
        else      data_sync <= {data_sync[0], PS2DATA};
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state decode, line drivers and datapath control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next  = state;
        clk_low     = 1'b0;
        data_low    = 1'b0;
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        shift_rx    = 1'b0;
        finish_rx   = 1'b0;
        ack_ok      = 1'b0;
        raise_fail  = 1'b0;
        cnt_restart = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A device clock edge wins over a simultaneous transmit request.
                if (strobe) begin
                    if (!data_s) state_next = ST_RX;
                end else if (tx_write) begin
                    load_tx    = 1'b1;
                    state_next = ST_TX_INHIBIT;
                end
            end
            ST_RX: begin
                if (strobe) begin
                    cnt_restart = 1'b1;
                    if (bit_cnt == RX_LAST) begin
                        finish_rx  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        shift_rx = 1'b1;
                    end
                end else if (timeout) begin
                    raise_fail = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_TX_INHIBIT: begin
                // Our own low clock is seen as a strobe here; it is ignored.
                clk_low = 1'b1;
                if (cnt == INHIBIT_LAST) state_next = ST_TX_REQ;
            end
            ST_TX_REQ: begin
                data_low = 1'b1;
                if (strobe) begin
                    state_next = ST_TX_BITS;
                end else if (timeout) begin
                    raise_fail = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_TX_BITS: begin
                data_low = ~tx_shift[0];
                if (strobe) begin
                    cnt_restart = 1'b1;
                    if (bit_cnt == TX_LAST) state_next = ST_TX_ACK;
                    else                    shift_tx   = 1'b1;
                end else if (timeout) begin
                    raise_fail = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_TX_ACK: begin
                if (strobe) begin
                    if (!data_s) ack_ok     = 1'b1;
                    else         raise_fail = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    raise_fail = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Cycle counter (inhibit length / edge timeout) and per-frame bit counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            if (state_next != state || cnt_restart) cnt <= '0;
            else if (state != ST_IDLE)              cnt <= cnt + 1'b1;

            if (state_next != state)                 bit_cnt <= '0;
            else if (shift_rx || shift_tx)           bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Shift registers, received/response bytes, status flags and pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_shift   <= '0;
            tx_shift   <= '1;
            last_sent  <= '0;
            await_resp <= 1'b0;
            dataout    <= '0;
            DatoRec    <= '0;
            rx_done    <= 1'b0;
            tx_done    <= 1'b0;
            STREAM     <= 1'b0;
            FAIL       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            tx_done <= 1'b0;

            if (load_tx) begin
                tx_shift  <= {odd_parity(datain), datain};
                last_sent <= datain;
                FAIL      <= 1'b0;
                if (datain != CMD_ENABLE) STREAM <= 1'b0;
            end
            if (shift_tx) tx_shift <= {1'b1, tx_shift[8:1]};
            if (shift_rx) rx_shift <= {data_s, rx_shift[8:1]};

            if (finish_rx) begin
                if (frame_ok) begin
                    dataout <= rx_shift[7:0];
                    rx_done <= 1'b1;
                    if (await_resp) begin
                        DatoRec    <= rx_shift[7:0];
                        await_resp <= 1'b0;
                        if (rx_shift[7:0] == RESP_ACK && last_sent == CMD_ENABLE)
                            STREAM <= 1'b1;
                    end
                end else begin
                    FAIL <= 1'b1;
                end
            end

            if (ack_ok) begin
                tx_done    <= 1'b1;
                await_resp <= 1'b1;
            end
            if (raise_fail) FAIL <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prueba.sv
// Self-checking bench for prueba: a behavioural PS/2 device drives frames
// and clocks host transmits; a byte-level model predicts every output.
`timescale 1ns/1ps
module tb_prueba;

    localparam int HALF    = 40;     // device clock half-period in system cycles
    localparam int INH_CYC = 5000;   // 100 us at 50 MHz
    localparam int TO_CYC  = 5000;   // bench timeout of 100 us at 50 MHz

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       tx_write = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2clk, ps2data;
    logic       tx_done, rx_done, stream, fail;
    logic [7:0] dataout, datorec;

    assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    prueba #(.CLK_HZ(50_000_000), .INHIBIT_US(100), .TIMEOUT_US(100)) dut (
        .CLK(clk), .RST(rst_n), .PS2CLK(ps2clk), .PS2DATA(ps2data),
        .datain(datain), .tx_write(tx_write), .tx_done(tx_done),
        .dataout(dataout), .rx_done(rx_done), .DatoRec(datorec),
        .STREAM(stream), .FAIL(fail)
    );

    always #10 clk = ~clk;

    int checks = 0, failures = 0;
    int rx_pulses = 0, tx_pulses = 0;

    // Cycles spent high by each pulse output (a clean pulse adds exactly one).
    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_pulses++;
        if (tx_done === 1'b1) tx_pulses++;
    end

    // Reference model state, updated at byte level.
    logic [7:0] m_dataout = 8'h00, m_datorec = 8'h00, m_last_sent = 8'h00;
    logic       m_stream = 1'b0, m_fail = 1'b0, m_await = 1'b0;

    function automatic logic par_of(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    function automatic void model_rx(input logic [7:0] b, input bit ok);
        if (ok) begin
            m_dataout = b;
            if (m_await) begin
                m_datorec = b;
                m_await   = 1'b0;
                if (b == 8'hFA && m_last_sent == 8'hF4) m_stream = 1'b1;
            end
        end else begin
            m_fail = 1'b1;
        end
    endfunction

    function automatic void model_tx_accept(input logic [7:0] b);
        m_last_sent = b;
        m_fail      = 1'b0;
        if (b != 8'hF4) m_stream = 1'b0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-to-host frame, optionally corrupted, optionally truncated.
    task automatic dev_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, par_of(b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~f[i];
            wait_cycles(HALF / 2);
            dev_clk_low = 1'b1;
            wait_cycles(HALF);
            dev_clk_low = 1'b0;
            wait_cycles(HALF / 2);
        end
        dev_data_low = 1'b0;
    endtask

    // Raises tx_write for 5 cycles and returns how many cycles PS2CLK was held low.
    task automatic request_tx(input logic [7:0] b, output int n);
        datain = b; tx_write = 1'b1; n = 0;
        for (int c = 0; c < INH_CYC + 100; c++) begin
            @(negedge clk);
            if (c == 4) tx_write = 1'b0;
            if (ps2clk === 1'b0) n++;
            else if (n > 0) break;
        end
        tx_write = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(5);
        checks++; if ({tx_done, rx_done, stream, fail} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags: got %b required 0000", {tx_done, rx_done, stream, fail}); end
        checks++; if (dataout !== 8'h00) begin failures++;
            $display("FAIL reset_dataout: got %h required 00", dataout); end
        checks++; if (datorec !== 8'h00) begin failures++;
            $display("FAIL reset_datorec: got %h required 00", datorec); end
        checks++; if ({ps2clk, ps2data} !== 2'b11) begin failures++;
            $display("FAIL reset_lines: got %b required 11 (released)", {ps2clk, ps2data}); end
    endtask

    task automatic test_host_tx(input logic [7:0] b);
        int n, t0;
        logic [10:0] got;
        t0 = tx_pulses;
        request_tx(b, n);
        checks++; if (n != INH_CYC) begin failures++;
            $display("FAIL tx_inhibit_len: got %0d required %0d", n, INH_CYC); end
        checks++; if (ps2data !== 1'b0) begin failures++;
            $display("FAIL tx_request_data: got %b required 0", ps2data); end
        for (int k = 0; k < 11; k++) begin
            wait_cycles(HALF);
            got[k] = ps2data;
            if (k == 10) begin
                dev_data_low = 1'b1;   // acknowledge
                wait_cycles(4);
            end
            dev_clk_low = 1'b1;
            wait_cycles(HALF);
            dev_clk_low = 1'b0;
        end
        wait_cycles(HALF / 2);
        dev_data_low = 1'b0;
        wait_cycles(20);
        model_tx_accept(b);
        m_await = 1'b1;
        checks++; if (got[0] !== 1'b0 || got[10] !== 1'b1) begin failures++;
            $display("FAIL tx_start_stop: got %b/%b required 0/1", got[0], got[10]); end
        checks++; if (got[8:1] !== b) begin failures++;
            $display("FAIL tx_data_bits: got %h required %h", got[8:1], b); end
        checks++; if (got[9] !== par_of(b)) begin failures++;
            $display("FAIL tx_parity: got %b required %b", got[9], par_of(b)); end
        checks++; if (tx_pulses - t0 != 1) begin failures++;
            $display("FAIL tx_done_pulse: got %0d cycles required 1", tx_pulses - t0); end
        checks++; if (fail !== m_fail || stream !== m_stream) begin failures++;
            $display("FAIL tx_flags: got fail=%b stream=%b required %b %b", fail, stream, m_fail, m_stream); end
    endtask

    task automatic test_response(input logic [7:0] b);
        int t0;
        t0 = rx_pulses;
        dev_frame(b, 1'b0, 1'b0, 11);
        wait_cycles(30);
        model_rx(b, 1'b1);
        checks++; if (rx_pulses - t0 != 1) begin failures++;
            $display("FAIL resp_rx_pulse: got %0d required 1", rx_pulses - t0); end
        checks++; if (dataout !== m_dataout || datorec !== m_datorec) begin failures++;
            $display("FAIL resp_bytes: got %h/%h required %h/%h", dataout, datorec, m_dataout, m_datorec); end
        checks++; if (stream !== m_stream) begin failures++;
            $display("FAIL resp_stream: got %b required %b", stream, m_stream); end
    endtask

    task automatic test_bad_parity;
        int t0;
        t0 = rx_pulses;
        dev_frame(8'h08, 1'b1, 1'b0, 11);
        wait_cycles(30);
        model_rx(8'h08, 1'b0);
        checks++; if (fail !== 1'b1) begin failures++;
            $display("FAIL badpar_flag: got %b required 1", fail); end
        checks++; if (rx_pulses != t0) begin failures++;
            $display("FAIL badpar_pulse: got %0d required 0", rx_pulses - t0); end
        checks++; if (dataout !== m_dataout) begin failures++;
            $display("FAIL badpar_dataout: got %h required %h", dataout, m_dataout); end
    endtask

    task automatic test_rx_sequence;
        logic [7:0] seq [3];
        int t0;
        seq = '{8'h08, 8'h01, 8'hFF};
        t0 = rx_pulses;
        for (int i = 0; i < 3; i++) begin
            dev_frame(seq[i], 1'b0, 1'b0, 11);
            wait_cycles(HALF);
            model_rx(seq[i], 1'b1);
        end
        checks++; if (rx_pulses - t0 != 3) begin failures++;
            $display("FAIL seq_pulses: got %0d required 3", rx_pulses - t0); end
        checks++; if (dataout !== 8'hFF || datorec !== 8'hFA || stream !== 1'b1) begin failures++;
            $display("FAIL seq_outputs: got %h %h %b required ff fa 1", dataout, datorec, stream); end
        checks++; if (fail !== m_fail) begin failures++;
            $display("FAIL seq_sticky: got %b required %b", fail, m_fail); end
    endtask

    task automatic test_random_rx;
        logic [7:0] b;
        bit bad, bad_par;
        int t0;
        for (int i = 0; i < 8; i++) begin
            b       = 8'($urandom_range(0, 255));
            bad     = ($urandom_range(0, 3) == 0);
            bad_par = bad && ($urandom_range(0, 1) == 1);
            t0      = rx_pulses;
            dev_frame(b, bad_par, bad && !bad_par, 11);
            wait_cycles(HALF);
            model_rx(b, !bad);
            checks++; if (rx_pulses - t0 != (bad ? 0 : 1)) begin failures++;
                $display("FAIL rand_rx_pulse[%0d]: got %0d required %0d", i, rx_pulses - t0, bad ? 0 : 1); end
            checks++; if (dataout !== m_dataout || fail !== m_fail) begin failures++;
                $display("FAIL rand_rx[%0d]: got %h/%b required %h/%b", i, dataout, fail, m_dataout, m_fail); end
        end
    endtask

    task automatic test_random_tx;
        logic [7:0] b, r;
        b = 8'($urandom_range(0, 255));
        r = ($urandom_range(0, 1) == 1) ? 8'hFA : 8'($urandom_range(0, 255));
        test_host_tx(b);
        test_response(r);
    endtask

    task automatic test_timeout;
        int n, c, t0;
        t0 = tx_pulses;
        request_tx(8'hFF, n);
        checks++; if (n != INH_CYC) begin failures++;
            $display("FAIL to_inhibit_len: got %0d required %0d", n, INH_CYC); end
        c = 0;
        while (fail !== 1'b1 && c < 2 * TO_CYC) begin
            @(negedge clk);
            c++;
        end
        model_tx_accept(8'hFF);
        m_fail = 1'b1;
        checks++; if (fail !== 1'b1) begin failures++;
            $display("FAIL to_flag: got %b after %0d cycles required 1", fail, c); end
        checks++; if (c < TO_CYC - 20 || c > TO_CYC + 20) begin failures++;
            $display("FAIL to_latency: got %0d cycles required about %0d", c, TO_CYC); end
        wait_cycles(5);
        checks++; if (stream !== m_stream || tx_pulses != t0) begin failures++;
            $display("FAIL to_state: got stream=%b tx_done=%0d required %b 0", stream, tx_pulses - t0, m_stream); end
        checks++; if ({ps2clk, ps2data} !== 2'b11) begin failures++;
            $display("FAIL to_lines: got %b required 11", {ps2clk, ps2data}); end
        // Back in IDLE: a valid frame is received and FAIL stays set.
        t0 = rx_pulses;
        dev_frame(8'h3C, 1'b0, 1'b0, 11);
        wait_cycles(30);
        model_rx(8'h3C, 1'b1);
        checks++; if (rx_pulses - t0 != 1 || dataout !== m_dataout || fail !== m_fail) begin failures++;
            $display("FAIL to_recover: got %0d %h %b required 1 %h %b", rx_pulses - t0, dataout, fail, m_dataout, m_fail); end
    endtask

    task automatic test_reset_midframe;
        int t0;
        t0 = rx_pulses;
        dev_frame(8'h55, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        wait_cycles(3);
        checks++; if (rx_pulses != t0 || dataout !== 8'h00 || fail !== 1'b0 || datorec !== 8'h00) begin failures++;
            $display("FAIL midreset_outputs: got %0d %h %b %h required 0 00 0 00", rx_pulses - t0, dataout, fail, datorec); end
        rst_n = 1'b1;
        m_dataout = 8'h00; m_datorec = 8'h00; m_last_sent = 8'h00;
        m_stream = 1'b0; m_fail = 1'b0; m_await = 1'b0;
        wait_cycles(20);
        dev_frame(8'hA7, 1'b0, 1'b0, 11);
        wait_cycles(30);
        model_rx(8'hA7, 1'b1);
        checks++; if (rx_pulses - t0 != 1 || dataout !== m_dataout || datorec !== m_datorec) begin failures++;
            $display("FAIL midreset_restart: got %0d %h %h required 1 %h %h", rx_pulses - t0, dataout, datorec, m_dataout, m_datorec); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_host_tx(8'hF4);
        test_response(8'hFA);
        test_bad_parity();
        test_rx_sequence();
        test_random_rx();
        test_random_tx();
        test_timeout();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prueba.md
PRUEBA -- requirements
Module: prueba

Interface
REQ-001 CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 INHIBIT_US, default 100, host clock-inhibit time before a transmit.
REQ-003 TIMEOUT_US, default 2000, maximum wait for any device clock edge inside a frame.
REQ-004 CLK  input  1  system clock; all logic on the rising edge; one clock domain.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 PS2CLK  inout  1  PS/2 clock; open-drain: driven 0 or released (Z).
REQ-007 PS2DATA  inout  1  PS/2 data; open-drain: driven 0 or released (Z).
REQ-008 datain  input  8  byte to send to the device.
REQ-009 tx_write  input  1  transmit request; level or pulse; accepted only in IDLE.
REQ-010 tx_done  output  1  one-cycle pulse when the device acknowledges a transmit.
REQ-011 dataout  output  8  most recent valid received byte.
REQ-012 rx_done  output  1  one-cycle pulse when a valid byte is received.
REQ-013 DatoRec  output  8  first valid byte received after the last completed transmit (the device response).
REQ-014 STREAM  output  1  high while the device is in stream mode.
REQ-015 FAIL  output  1  sticky error flag.

Function
REQ-016 PS2CLK and PS2DATA: synchronised by 2 flip-flops; PS2CLK also glitch-filtered (8 equal consecutive samples); a filtered falling edge is the bit strobe.
REQ-017 States: IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK.
REQ-018 RX frame: 11 bits, each sampled on a strobe: start 0, d0..d7 LSB first, odd parity, stop 1.
REQ-019 IDLE -> RX on a strobe with PS2DATA=0.
REQ-020 Valid RX frame: dataout updated and rx_done pulsed one cycle after the stop-bit strobe; then IDLE.
REQ-021 Bad RX frame (parity or stop bit wrong): FAIL set; dataout and rx_done unchanged; return to IDLE.
REQ-022 IDLE with tx_write=1: datain latched, FAIL cleared, TX_INHIBIT entered.
REQ-023 TX_INHIBIT: PS2CLK driven low for CLK_HZ*INHIBIT_US/1e6 cycles (5000 at defaults).
REQ-024 TX_REQ: PS2DATA driven low and PS2CLK released.
REQ-025 TX_BITS: on each strobe, PS2DATA presents the next of d0..d7 (LSB first) then odd parity; a 1 is a release.
REQ-026 TX_BITS: on the next strobe PS2DATA is released (stop bit), then TX_ACK.
REQ-027 TX_ACK: the next strobe with PS2DATA=0 pulses tx_done and returns to IDLE; PS2DATA=1 sets FAIL.
REQ-028 Timeout: in RX, TX_REQ, TX_BITS or TX_ACK, no strobe within TIMEOUT_US sets FAIL, releases both lines and returns to IDLE.
REQ-029 tx_write is ignored outside IDLE; a strobe arriving in the same cycle as tx_write takes priority (RX).
REQ-030 DatoRec is loaded with the first valid byte after tx_done.
REQ-031 STREAM is set when that byte is 0xFA and the last sent byte was 0xF4; it is cleared by any other accepted transmit.
REQ-032 Both lines are released in IDLE and RX.

Reset
REQ-033 RST low: state IDLE, lines released, dataout=DatoRec=0x00, tx_done=rx_done=STREAM=FAIL=0, counters and filters cleared.
REQ-034 Reset mid-frame aborts immediately with no pulse.

Structure
REQ-035 A shared package holds the state enum, frame length 11, and the command constants 0xF4 and 0xFA.
REQ-036 One sub-module, ps2_line_filter, performs synchronisation, glitch filtering and falling-edge strobe generation; prueba instantiates it for PS2CLK.

Verification
REQ-037 Reset release -> all outputs 0, both lines Z.
REQ-038 tx_write=1 for 5 cycles with datain=0xF4 -> PS2CLK low for 5000 cycles; device model reads bits 0,0,1,0,1,1,1,1, parity 0, stop 1, drives ack 0 -> one tx_done pulse.
REQ-039 Then device sends 0xFA (parity 1) -> dataout=DatoRec=0xFA, one rx_done pulse, STREAM=1.
REQ-040 Device sends 0x08 with parity forced wrong -> FAIL=1, no rx_done, dataout stays 0xFA.
REQ-041 Device sends 0x08, 0x01, 0xFF validly -> three rx_done pulses, dataout=0xFF, DatoRec=0xFA, STREAM=1.
REQ-042 tx_write with datain=0xFF and no device clock -> FAIL=1 after 2000 us, return to IDLE, STREAM=0.
